// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave exposing NUM_REGS DATA_W-bit registers with byte strobes.
// Independent write (AW/W/B) and read (AR/R) channels; bad writes get SLVERR.
//
// Ports:
//   ACLK, ARESET            clock, async active-high reset
//   AW*/W*/B*               write address, data and response channels
//   AR*/R*                  read address and data channels
//   AWPROT/ARPROT           accepted and ignored
module axi_lite_regfile_slave #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [2:0]          AWPROT,
  input  logic                WVALID,
  output logic                WREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [1:0]          BRESP,
  input  logic                ARVALID,
  output logic                ARREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [2:0]          ARPROT,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP
);

  localparam int NB  = DATA_W / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = ADDR_W - LSB;
  localparam int RW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  w_state_e            w_state_q, w_state_d;
  r_state_e            r_state_q, r_state_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [IW-1:0]       waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       wstrb_q, wstrb_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic                aw_hs, w_hs, ar_hs, do_wr;
  logic                w_ok, r_in;
  logic [RW-1:0]       widx, ridx;
  logic [IW-1:0]       raddr;

  logic unused_ok;
  assign unused_ok = ^{AWPROT, ARPROT,
                       AWADDR[LSB-1:0], ARADDR[LSB-1:0]};

  assign aw_hs = AWVALID & awready_q;
  assign w_hs  = WVALID & wready_q;
  assign ar_hs = ARVALID & arready_q;

  // Write side: the second handshake may come from this cycle's bus
  // or from the half already latched, so decode the merged view.
  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = aw_hs ? AWADDR[ADDR_W-1:LSB] : waddr_q;
    wdata_d   = w_hs ? WDATA : wdata_q;
    wstrb_d   = w_hs ? WSTRB : wstrb_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    do_wr     = 1'b0;
    widx      = waddr_d[RW-1:0];
    w_ok      = (64'(waddr_d) < 64'(NUM_REGS)) &&
                !RO_MASK[widx];

    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) do_wr = 1'b1;
        else if (aw_hs)    w_state_d = W_HAVE_AW;
        else if (w_hs)     w_state_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  do_wr = 1'b1;
      W_HAVE_W:  if (aw_hs) do_wr = 1'b1;
      W_RESP:    if (BREADY) w_state_d = W_IDLE;
      default:   w_state_d = W_IDLE;
    endcase

    if (do_wr) begin
      w_state_d = W_RESP;
      bresp_d   = w_ok ? OKAY : SLVERR;
      if (w_ok) begin
        for (int b = 0; b < NB; b++) begin
          if (wstrb_d[b])
            regs_d[widx][8*b +: 8] = wdata_d[8*b +: 8];
        end
      end
    end

    awready_d = (w_state_d == W_IDLE) ||
                (w_state_d == W_HAVE_W);
    wready_d  = (w_state_d == W_IDLE) ||
                (w_state_d == W_HAVE_AW);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Read side samples regs_q, so a same-edge write is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    raddr     = ARADDR[ADDR_W-1:LSB];
    ridx      = raddr[RW-1:0];
    r_in      = 64'(raddr) < 64'(NUM_REGS);

    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rdata_d   = r_in ? regs_q[ridx] : '0;
          rresp_d   = r_in ? OKAY : SLVERR;
        end
      end
      R_DATA:  if (RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase

    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      regs_q    <= '{default: '0};
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      regs_q    <= regs_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed bench for axi_lite_regfile_slave: vector table plus
// hand-written sequences for ordering, back-pressure and reset cases.
module tb_axi_lite_regfile_slave;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] AWADDR = '0;
  logic [2:0]  AWPROT = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [1:0]  BRESP;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] ARADDR = '0;
  logic [2:0]  ARPROT = '0;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  int total = 0;
  int bad = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_regfile_slave #(
    .DATA_W(32),
    .ADDR_W(32),
    .NUM_REGS(16),
    .RO_MASK(16'h0008)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY),
    .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY),
    .RDATA(RDATA), .RRESP(RRESP)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // mode 0: AW+W together, 1: W two cycles before AW, 2: AW first
  task automatic axw(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0] s,
                     input int mode,
                     output logic [1:0] resp,
                     output int lat);
    bit awd, wd, aw_now, w_now;
    int c;
    awd = 0; wd = 0; c = 0; lat = 0;
    @(negedge ACLK);
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = (mode != 1);
    WVALID  = (mode != 2);
    while (!(awd && wd) && c < 30) begin
      aw_now = AWVALID && AWREADY;
      w_now  = WVALID && WREADY;
      @(negedge ACLK);
      c++;
      if (aw_now) begin AWVALID = 0; awd = 1; end
      if (w_now)  begin WVALID = 0;  wd = 1;  end
      if (c == 2 && mode == 1) AWVALID = 1;
      if (c == 2 && mode == 2) WVALID = 1;
    end
    AWVALID = 0; WVALID = 0;
    chk("w_handshakes", {awd, wd}, 2'b11);
    while (!BVALID && lat < 30) begin
      @(negedge ACLK);
      lat++;
    end
    chk("w_bvalid", BVALID, 1'b1);
    resp = BRESP;
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    chk("w_bvalid_drop", BVALID, 1'b0);
  endtask

  task automatic axr(input logic [31:0] a,
                     input int hold,
                     input logic [31:0] ed,
                     input logic [1:0] er,
                     input string nm);
    int c;
    c = 0;
    @(negedge ACLK);
    ARADDR = a; ARVALID = 1;
    while (!ARREADY && c < 30) begin
      @(negedge ACLK);
      c++;
    end
    chk({nm, "_arready"}, ARREADY, 1'b1);
    @(negedge ACLK);
    ARVALID = 0;
    chk({nm, "_rvalid"}, RVALID, 1'b1);
    chk({nm, "_rdata"}, RDATA, ed);
    chk({nm, "_rresp"}, RRESP, er);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      chk({nm, "_hold_flags"}, {RVALID, ARREADY}, 2'b10);
      chk({nm, "_hold_data"}, {RDATA, RRESP}, {ed, er});
    end
    RREADY = 1;
    @(negedge ACLK);
    RREADY = 0;
    chk({nm, "_rvalid_drop"}, RVALID, 1'b0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp;
    int lat;

    vt[0]  = '{1, 32'h08, 32'hDEADBEEF, 4'hF, 2'b00};
    vt[1]  = '{0, 32'h08, 32'hDEADBEEF, 4'h0, 2'b00};
    vt[2]  = '{1, 32'h04, 32'h11223344, 4'hF, 2'b00};
    vt[3]  = '{0, 32'h04, 32'h11223344, 4'h0, 2'b00};
    vt[4]  = '{1, 32'h40, 32'hCAFEF00D, 4'hF, 2'b10};
    vt[5]  = '{0, 32'h40, 32'h00000000, 4'h0, 2'b10};
    vt[6]  = '{1, 32'h0C, 32'h12345678, 4'hF, 2'b10};
    vt[7]  = '{0, 32'h0C, 32'h00000000, 4'h0, 2'b00};
    vt[8]  = '{1, 32'h10, 32'hAABBCCDD, 4'h0, 2'b00};
    vt[9]  = '{0, 32'h10, 32'h00000000, 4'h0, 2'b00};
    vt[10] = '{1, 32'h3C, 32'hFFFFFFFF, 4'h9, 2'b00};
    vt[11] = '{0, 32'h3C, 32'hFF0000FF, 4'h0, 2'b00};
    vt[12] = '{1, 32'h0A, 32'h00000055, 4'h1, 2'b00};
    vt[13] = '{0, 32'h09, 32'hDEADBE55, 4'h0, 2'b00};

    repeat (3) @(negedge ACLK);
    chk("rst_flags",
        {AWREADY, WREADY, BVALID, ARREADY, RVALID}, 5'b0);
    chk("rst_data", {BRESP, RRESP, RDATA}, 36'h0);
    ARESET = 0;
    #1;
    chk("rel_ready_early", {AWREADY, WREADY, ARREADY}, 3'b000);
    @(negedge ACLK);
    chk("rel_ready", {AWREADY, WREADY, ARREADY}, 3'b111);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].wr) begin
        axw(vt[i].addr, vt[i].data, vt[i].strb, 0, resp, lat);
        chk($sformatf("v%0d_bresp", i), resp, vt[i].resp);
        chk($sformatf("v%0d_blat", i), lat, 0);
      end else begin
        axr(vt[i].addr, 0, vt[i].data, vt[i].resp,
            $sformatf("v%0d", i));
      end
    end

    axw(32'h04, 32'h0000AB00, 4'h2, 1, resp, lat);
    chk("wfirst_bresp", resp, 2'b00);
    axr(32'h04, 0, 32'h1122AB44, 2'b00, "wfirst");

    axw(32'h14, 32'h5A5A1234, 4'hF, 2, resp, lat);
    chk("awfirst_bresp", resp, 2'b00);
    axr(32'h14, 0, 32'h5A5A1234, 2'b00, "awfirst");

    axr(32'h08, 5, 32'hDEADBE55, 2'b00, "bp");
    axr(32'h00, 0, 32'h0, 2'b00, "reg0_clean");

    axw(32'h18, 32'h11111111, 4'hF, 0, resp, lat);
    @(negedge ACLK);
    AWADDR = 32'h18; WDATA = 32'h22222222; WSTRB = 4'hF;
    ARADDR = 32'h18;
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    chk("same_edge_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    chk("same_edge_valid", {BVALID, RVALID}, 2'b11);
    chk("same_edge_rdata", RDATA, 32'h11111111);
    BREADY = 1; RREADY = 1;
    @(negedge ACLK);
    BREADY = 0; RREADY = 0;
    axr(32'h18, 0, 32'h22222222, 2'b00, "same_edge_after");

    @(negedge ACLK);
    AWADDR = 32'h1C; WDATA = 32'h77777777; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    chk("pre_rst_bvalid", BVALID, 1'b1);
    #2;
    ARESET = 1;
    #1;
    chk("mid_rst_flags",
        {AWREADY, WREADY, BVALID, ARREADY, RVALID}, 5'b0);
    repeat (2) @(negedge ACLK);
    ARESET = 0;
    @(negedge ACLK);
    axr(32'h08, 0, 32'h0, 2'b00, "post_rst_r2");
    axr(32'h1C, 0, 32'h0, 2'b00, "post_rst_r7");
    axr(32'h04, 0, 32'h0, 2'b00, "post_rst_r1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
